hilo_md_unit: RTL and testbench

HILO_MD_UNIT -- requirements
Module: hilo_md_unit

---
 rtl/hilo_md_unit.sv | 113 +++++++++++
 tb/tb_hilo_md_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_md_unit.sv
// HI/LO multiply-divide unit: fixed-latency mult/div with HI/LO registers and mt/mf access.
// Revision 1.0 - initial release.
`default_nettype none

module hilo_md_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  HILOtype,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] HILOout
);

  localparam logic [3:0] C_OP_MULT  = 4'd1;
  localparam logic [3:0] C_OP_MULTU = 4'd2;
  localparam logic [3:0] C_OP_DIV   = 4'd3;
  localparam logic [3:0] C_OP_DIVU  = 4'd4;
  localparam logic [3:0] C_OP_MTHI  = 4'd5;
  localparam logic [3:0] C_OP_MTLO  = 4'd6;
  localparam logic [3:0] C_OP_MFHI  = 4'd7;
  localparam logic [3:0] C_OP_MFLO  = 4'd8;

  localparam logic [3:0] C_MUL_CYCLES = 4'd5;
  localparam logic [3:0] C_DIV_CYCLES = 4'd10;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [3:0]  r_cnt;
  logic [63:0] r_res;
  logic        r_commit;

  logic               w_is_md;
  logic               w_is_div;
  logic               w_start;
  logic               w_div_zero;
  logic [31:0]        w_div_b;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic signed [31:0] w_quo_s;
  logic signed [31:0] w_rem_s;
  logic [31:0]        w_quo_u;
  logic [31:0]        w_rem_u;
  logic [63:0]        w_result;

  assign w_is_md    = (HILOtype == C_OP_MULT) || (HILOtype == C_OP_MULTU) ||
                      (HILOtype == C_OP_DIV)  || (HILOtype == C_OP_DIVU);
  assign w_is_div   = (HILOtype == C_OP_DIV)  || (HILOtype == C_OP_DIVU);
  assign w_start    = w_is_md && !busy && !req;
  assign w_div_zero = (B == 32'd0);

  // A zero divisor is replaced by 1 so the divider never sees /0; its result is discarded.
  assign w_div_b  = w_div_zero ? 32'd1 : B;
  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};
  assign w_quo_s  = $signed(A) / $signed(w_div_b);
  assign w_rem_s  = $signed(A) % $signed(w_div_b);
  assign w_quo_u  = A / w_div_b;
  assign w_rem_u  = A % w_div_b;

  always_comb begin
    w_result = 64'd0;
    case (HILOtype)
      C_OP_MULT:  w_result = w_prod_s;
      C_OP_MULTU: w_result = w_prod_u;
      C_OP_DIV:   w_result = {w_rem_s, w_quo_s};
      C_OP_DIVU:  w_result = {w_rem_u, w_quo_u};
      default:    w_result = 64'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_cnt    <= 4'd0;
      r_res    <= 64'd0;
      r_commit <= 1'b0;
    end else if (w_start) begin
      r_cnt    <= w_is_div ? C_DIV_CYCLES : C_MUL_CYCLES;
      r_res    <= w_result;
      r_commit <= !(w_is_div && w_div_zero);
    end else if (r_cnt != 4'd0) begin
      // Operation in flight runs to completion regardless of req.
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1 && r_commit) begin
        r_hi <= r_res[63:32];
        r_lo <= r_res[31:0];
      end
    end else if (!req) begin
      if (HILOtype == C_OP_MTHI) r_hi <= A;
      if (HILOtype == C_OP_MTLO) r_lo <= A;
    end
  end

  assign busy  = (r_cnt != 4'd0);
  assign start = w_start;
  assign HI    = r_hi;
  assign LO    = r_lo;

  always_comb begin
    HILOout = 32'd0;
    if (HILOtype == C_OP_MFHI) HILOout = r_hi;
    if (HILOtype == C_OP_MFLO) HILOout = r_lo;
  end

endmodule

`default_nettype wire

// File: tb/tb_hilo_md_unit.sv
// Scoreboard bench for hilo_md_unit: timeline reference model, per-cycle expected outputs.
`default_nettype none

module tb_hilo_md_unit;

  logic        clk;
  logic        reset_s;
  logic [3:0]  type_s;
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic        req_s;
  logic        start_o;
  logic        busy_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] hout_o;

  hilo_md_unit dut (
    .clk      (clk),
    .reset    (reset_s),
    .HILOtype (type_s),
    .A        (a_s),
    .B        (b_s),
    .req      (req_s),
    .start    (start_o),
    .busy     (busy_o),
    .HI       (hi_o),
    .LO       (lo_o),
    .HILOout  (hout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        st;
    logic        bz;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] ho;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: architectural HI/LO plus a timeline of the op in flight.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          cyc_n = 0;
  bit          op_on = 0;
  int          st_cyc = 0;
  int          dur = 0;
  bit          pend_on = 0;
  bit          pend_wr = 0;
  int          commit_at = 0;
  logic [63:0] pend = 64'd0;

  function automatic logic [63:0] md_result(input logic [3:0] ht, input logic [31:0] a, input logic [31:0] b);
    longint          ps;
    longint unsigned pu;
    int              qs, rs;
    logic [31:0]     qu, ru;
    md_result = 64'd0;
    case (ht)
      4'd1: begin ps = longint'(signed'(a)) * longint'(signed'(b)); md_result = ps; end
      4'd2: begin pu = longint'(a) * longint'(b); md_result = pu; end
      4'd3: begin qs = signed'(a) / signed'(b); rs = signed'(a) % signed'(b); md_result = {rs, qs}; end
      4'd4: begin qu = a / b; ru = a % b; md_result = {ru, qu}; end
      default: md_result = 64'd0;
    endcase
  endfunction

  task automatic step(input logic [3:0] ht, input logic [31:0] a, input logic [31:0] b,
                      input logic rq, input logic rs);
    exp_t e;
    bit   bz, md, st;
    @(negedge clk);
    type_s = ht; a_s = a; b_s = b; req_s = rq; reset_s = rs;
    cyc_n++;
    if (pend_on && cyc_n == commit_at) begin
      if (pend_wr) begin m_hi = pend[63:32]; m_lo = pend[31:0]; end
      pend_on = 0;
    end
    if (rs) begin
      op_on = 0; pend_on = 0; m_hi = 32'd0; m_lo = 32'd0;
    end
    bz = op_on && (cyc_n > st_cyc) && (cyc_n <= st_cyc + dur);
    md = (ht >= 4'd1) && (ht <= 4'd4);
    st = md && !bz && !rq;
    e.cyc = cyc_n; e.st = st; e.bz = bz; e.hi = m_hi; e.lo = m_lo;
    e.ho = (ht == 4'd7) ? m_hi : (ht == 4'd8) ? m_lo : 32'd0;
    q.push_back(e);
    if (rs) begin
      // held in reset across the edge: nothing is accepted
    end else if (st) begin
      op_on = 1; st_cyc = cyc_n; dur = (ht <= 4'd2) ? 5 : 10;
      pend_on = 1; commit_at = cyc_n + dur + 1;
      pend_wr = !(ht >= 4'd3 && b == 32'd0);
      pend = pend_wr ? md_result(ht, a, b) : 64'd0;
    end else if (!bz && !rq) begin
      if (ht == 4'd5) m_hi = a;
      if (ht == 4'd6) m_lo = a;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents its outputs, pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (start_o === e.st && busy_o === e.bz && hi_o === e.hi && lo_o === e.lo && hout_o === e.ho)
          n_pass++;
        else
          $display("FAIL cycle %0d: got start=%b busy=%b HI=%h LO=%h HILOout=%h, expected start=%b busy=%b HI=%h LO=%h HILOout=%h",
                   e.cyc, start_o, busy_o, hi_o, lo_o, hout_o, e.st, e.bz, e.hi, e.lo, e.ho);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  ht;
    logic [31:0] ra, rb;
    reset_s = 1'b1; type_s = 4'd0; a_s = 32'd0; b_s = 32'd0; req_s = 1'b0;

    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    idle(2);

    step(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    idle(6);
    step(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    idle(6);
    step(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    idle(11);

    step(4'd5, 32'h12, 32'd0, 1'b0, 1'b0);
    step(4'd6, 32'h34, 32'd0, 1'b0, 1'b0);
    step(4'd4, 32'd7, 32'd0, 1'b0, 1'b0);
    idle(11);
    step(4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    step(4'd8, 32'd0, 32'd0, 1'b0, 1'b0);

    step(4'd1, 32'd3, 32'd4, 1'b1, 1'b0);
    idle(2);
    step(4'd6, 32'h55, 32'd0, 1'b1, 1'b0);
    step(4'd8, 32'd0, 32'd0, 1'b0, 1'b0);

    // reset lands in the third busy cycle of a divu
    step(4'd4, 32'd100, 32'd7, 1'b0, 1'b0);
    idle(2);
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    idle(12);

    step(4'd3, 32'd1000, 32'd7, 1'b0, 1'b0);
    step(4'd5, 32'hAA, 32'd0, 1'b0, 1'b0);
    step(4'd1, 32'd9, 32'd9, 1'b0, 1'b0);
    idle(9);
    step(4'd7, 32'd0, 32'd0, 1'b0, 1'b0);

    for (int c = 9; c < 16; c++) step(4'(c), 32'h5A5A_5A5A, 32'd3, 1'b0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      ht = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
      if (ht == 4'd3 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      step(ht, ra, rb, ($urandom_range(0, 7) == 0), ($urandom_range(0, 149) == 0));
    end
    idle(12);

    @(negedge clk);
    #5;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
